// File: rtl/hack_bus_pkg.sv
// hack_bus_pkg: shared widths, arbiter states and the round-robin winner search
package hack_bus_pkg;
    localparam int WIDTH = 16;
    localparam int NREQ  = 4;

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    // Scan ptr, ptr+1, ... (mod NREQ); walking backwards lets the nearest requester win.
    function automatic logic [1:0] next_rr(input logic [NREQ-1:0] req, input logic [1:0] ptr);
        logic [1:0] w;
        w = ptr;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[ptr + 2'(i)]) w = ptr + 2'(i);
        return w;
    endfunction
endpackage

// File: rtl/bus_mux4way16.sv
// bus_mux4way16: 4:1 word mux as a two-level tree of mux16_gate
module bus_mux4way16
    import hack_bus_pkg::*;
(
    input  logic [4*WIDTH-1:0] din,
    input  logic [1:0]         sel,
    output logic [WIDTH-1:0]   y
);
    logic [WIDTH-1:0] lo, hi;

    mux16_gate u_lo (.a(din[0*WIDTH +: WIDTH]), .b(din[1*WIDTH +: WIDTH]), .s(sel[0]), .y(lo));
    mux16_gate u_hi (.a(din[2*WIDTH +: WIDTH]), .b(din[3*WIDTH +: WIDTH]), .s(sel[0]), .y(hi));
    mux16_gate u_root (.a(lo), .b(hi), .s(sel[1]), .y(y));
endmodule

// File: rtl/mux16_gate.sv
// mux16_gate: 2:1 mux of two data words
module mux16_gate
    import hack_bus_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);
    assign y = s ? b : a;
endmodule

// File: rtl/rr_bus_arbiter16.sv
// rr_bus_arbiter16: round-robin owner of a shared 16-bit datapath with a per-grant beat limit
module rr_bus_arbiter16
    import hack_bus_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       last,
    input  logic [NREQ*WIDTH-1:0] din,
    output logic [NREQ-1:0]       gnt,
    output logic [1:0]            sel,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  bus_valid,
    output logic                  busy
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n, sel_n, win;
    logic [NREQ-1:0]  gnt_n;
    logic [HW-1:0]    hold_cnt, hold_n, cnt_inc;
    logic [WIDTH-1:0] mux_out;
    logic             rel;

    bus_mux4way16 u_mux (.din(din), .sel(sel), .y(mux_out));

    assign busy      = state == ST_GRANT;
    assign bus_valid = busy && req[sel];
    assign bus_out   = busy ? mux_out : '0;
    assign win       = next_rr(req, ptr);
    assign cnt_inc   = hold_cnt + HW'(1);
    // Owner withdrawal, its last beat, or the beat that reaches the limit all end the grant.
    assign rel       = busy && (!req[sel] || last[sel] || cnt_inc == HW'(MAX_HOLD));

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        gnt_n   = gnt;
        hold_n  = hold_cnt;
        if (state == ST_IDLE && |req) begin
            state_n = ST_GRANT;
            sel_n   = win;
            gnt_n   = NREQ'(1) << win;
            hold_n  = '0;
        end else if (rel) begin
            state_n = ST_IDLE;
            ptr_n   = sel + 2'd1;
            sel_n   = '0;
            gnt_n   = '0;
            hold_n  = '0;
        end else if (bus_valid) begin
            hold_n  = cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            sel      <= '0;
            gnt      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            sel      <= sel_n;
            gnt      <= gnt_n;
            hold_cnt <= hold_n;
        end
    end
endmodule
